// File: rtl/exe_stage.sv
// exe_stage - execute stage of the 5-stage LoongArch pipeline.
//
// Holds the ID->EXE payload in a pipeline register and feeds a registered
// opcode/operand set to the external ALU. It sequences the multi-cycle
// div/mod handshake (IDLE/BUSY/DONE) and captures the divider result. It
// issues the data-SRAM request, forwards the payload to MEM and drives the
// EXE->ID bypass tap.
//
// Ports:
//   clk, reset                   clock, synchronous active-high reset
//   ds_to_es_valid, es_allowin   ID->EXE handshake
//   ds_*                         ID payload (pc, opcode, operands, dest, ctrl)
//   alu_op/alu_src1/alu_src2     registered inputs to the ALU
//   alu_result, alu_dout_tvalid  ALU result; tvalid drops while div/mod pending
//   ms_allowin, es_to_ms_valid   EXE->MEM handshake
//   es_pc/result/dest/gr_we/res_from_mem   payload to MEM
//   data_sram_*                  data-SRAM request (one per instruction)
//   es_fwd_*                     bypass entry back to ID
//
// Optional feature macro: ES_DIVZERO_BYPASS_EN. When defined, a div/mod by
// zero skips the divider and yields the architectural result directly.
module exe_stage #(
  parameter int unsigned ALU_OP_W = 19,
  parameter int unsigned DEST_W   = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ds_to_es_valid,
  output logic                es_allowin,
  input  logic [31:0]         ds_pc,
  input  logic [ALU_OP_W-1:0] ds_alu_op,
  input  logic [31:0]         ds_src1,
  input  logic [31:0]         ds_src2,
  input  logic [31:0]         ds_rkd_value,
  input  logic [DEST_W-1:0]   ds_dest,
  input  logic                ds_gr_we,
  input  logic                ds_mem_we,
  input  logic                ds_res_from_mem,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic [31:0]         alu_src1,
  output logic [31:0]         alu_src2,
  input  logic [31:0]         alu_result,
  input  logic                alu_dout_tvalid,
  input  logic                ms_allowin,
  output logic                es_to_ms_valid,
  output logic [31:0]         es_pc,
  output logic [31:0]         es_result,
  output logic [DEST_W-1:0]   es_dest,
  output logic                es_gr_we,
  output logic                es_res_from_mem,
  output logic                data_sram_en,
  output logic [3:0]          data_sram_we,
  output logic [31:0]         data_sram_addr,
  output logic [31:0]         data_sram_wdata,
  output logic                es_fwd_valid,
  output logic [DEST_W-1:0]   es_fwd_dest,
  output logic [31:0]         es_fwd_data,
  output logic                es_fwd_is_load
);

  typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} div_state_e;

  div_state_e           div_state_q, div_state_d;
  logic                 es_valid_q;
  logic [31:0]          pc_q, src1_q, src2_q, rkd_q, div_res_q;
  logic [ALU_OP_W-1:0]  alu_op_q;
  logic [DEST_W-1:0]    dest_q;
  logic                 gr_we_q, mem_we_q, res_from_mem_q;

  logic es_ready_go;
  logic latch;
  logic is_div;
  logic ds_is_div;
  logic div_zero;
  logic ds_div_zero;

`ifdef ES_DIVZERO_BYPASS_EN
  assign div_zero    = es_valid_q & (|alu_op_q[18:15]) & (src2_q == '0);
  assign ds_div_zero = (|ds_alu_op[18:15]) & (ds_src2 == '0);
`else
  assign div_zero    = 1'b0;
  assign ds_div_zero = 1'b0;
`endif

  assign is_div    = es_valid_q & (|alu_op_q[18:15]) & ~div_zero;
  assign ds_is_div = (|ds_alu_op[18:15]) & ~ds_div_zero;
  assign latch     = es_allowin & ds_to_es_valid;

  // BUSY completes on the tvalid cycle itself so the result can leave with
  // alu_result still valid; a div sitting in IDLE waits one cycle so the
  // divider sees its start bit drop between back-to-back divisions.
  always_comb begin
    es_ready_go = 1'b1;
    unique case (div_state_q)
      DIV_IDLE: es_ready_go = ~is_div;
      DIV_BUSY: es_ready_go = alu_dout_tvalid;
      DIV_DONE: es_ready_go = 1'b1;
      default:  es_ready_go = 1'b1;
    endcase
  end

  assign es_allowin     = ~es_valid_q | (es_ready_go & ms_allowin);
  assign es_to_ms_valid = es_valid_q & es_ready_go;

  always_comb begin
    div_state_d = div_state_q;
    unique case (div_state_q)
      DIV_IDLE: if ((latch && ds_is_div) || is_div) div_state_d = DIV_BUSY;
      DIV_BUSY: if (alu_dout_tvalid) div_state_d = ms_allowin ? DIV_IDLE : DIV_DONE;
      DIV_DONE: if (ms_allowin) div_state_d = DIV_IDLE;
      default:  div_state_d = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_state_q    <= DIV_IDLE;
      es_valid_q     <= 1'b0;
      pc_q           <= '0;
      alu_op_q       <= '0;
      src1_q         <= '0;
      src2_q         <= '0;
      rkd_q          <= '0;
      dest_q         <= '0;
      gr_we_q        <= 1'b0;
      mem_we_q       <= 1'b0;
      res_from_mem_q <= 1'b0;
      div_res_q      <= '0;
    end else begin
      div_state_q <= div_state_d;
      if (es_allowin) es_valid_q <= ds_to_es_valid;
      if (latch) begin
        pc_q           <= ds_pc;
        alu_op_q       <= ds_alu_op;
        src1_q         <= ds_src1;
        src2_q         <= ds_src2;
        rkd_q          <= ds_rkd_value;
        dest_q         <= ds_dest;
        gr_we_q        <= ds_gr_we;
        mem_we_q       <= ds_mem_we;
        res_from_mem_q <= ds_res_from_mem;
      end
      if (div_state_q == DIV_BUSY && alu_dout_tvalid) div_res_q <= alu_result;
    end
  end

  // Div bits reach the ALU only while BUSY; this also masks them in DONE,
  // in the IDLE gap cycle and for a bypassed divide-by-zero.
  always_comb begin
    alu_op = '0;
    if (es_valid_q) begin
      alu_op = alu_op_q;
      if (div_state_q != DIV_BUSY) alu_op[18:15] = '0;
    end
  end

  assign alu_src1 = src1_q;
  assign alu_src2 = src2_q;

  always_comb begin
    es_result = alu_result;
    if (div_state_q == DIV_DONE) es_result = div_res_q;
`ifdef ES_DIVZERO_BYPASS_EN
    if (div_zero) es_result = (alu_op_q[15] | alu_op_q[16]) ? '1 : src1_q;
`endif
  end

  assign es_pc           = pc_q;
  assign es_dest         = dest_q;
  assign es_gr_we        = gr_we_q;
  assign es_res_from_mem = res_from_mem_q;

  assign data_sram_en    = es_valid_q & es_ready_go & ms_allowin & (mem_we_q | res_from_mem_q);
  assign data_sram_we    = {4{mem_we_q & data_sram_en}};
  assign data_sram_addr  = alu_result;
  assign data_sram_wdata = rkd_q;

  assign es_fwd_valid    = es_valid_q & gr_we_q & (dest_q != '0);
  assign es_fwd_dest     = dest_q;
  assign es_fwd_data     = es_result;
  assign es_fwd_is_load  = es_fwd_valid & (res_from_mem_q | ~es_ready_go);

endmodule

// File: tb/tb_exe_stage.sv
module tb_exe_stage;

  localparam int unsigned OPW = 19;
  localparam int unsigned DW  = 5;

  localparam logic [OPW-1:0] OP_ADD    = 19'h00001;
  localparam logic [OPW-1:0] OP_DIV_W  = 19'h08000;
  localparam logic [OPW-1:0] OP_MOD_WU = 19'h40000;

  logic            clk = 1'b0;
  logic            reset;
  logic            ds_to_es_valid;
  logic            es_allowin;
  logic [31:0]     ds_pc;
  logic [OPW-1:0]  ds_alu_op;
  logic [31:0]     ds_src1, ds_src2, ds_rkd_value;
  logic [DW-1:0]   ds_dest;
  logic            ds_gr_we, ds_mem_we, ds_res_from_mem;
  logic [OPW-1:0]  alu_op;
  logic [31:0]     alu_src1, alu_src2, alu_result;
  logic            alu_dout_tvalid;
  logic            ms_allowin;
  logic            es_to_ms_valid;
  logic [31:0]     es_pc, es_result;
  logic [DW-1:0]   es_dest;
  logic            es_gr_we, es_res_from_mem;
  logic            data_sram_en;
  logic [3:0]      data_sram_we;
  logic [31:0]     data_sram_addr, data_sram_wdata;
  logic            es_fwd_valid;
  logic [DW-1:0]   es_fwd_dest;
  logic [31:0]     es_fwd_data;
  logic            es_fwd_is_load;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  exe_stage #(.ALU_OP_W(OPW), .DEST_W(DW)) dut (
    .clk(clk), .reset(reset),
    .ds_to_es_valid(ds_to_es_valid), .es_allowin(es_allowin),
    .ds_pc(ds_pc), .ds_alu_op(ds_alu_op), .ds_src1(ds_src1), .ds_src2(ds_src2),
    .ds_rkd_value(ds_rkd_value), .ds_dest(ds_dest), .ds_gr_we(ds_gr_we),
    .ds_mem_we(ds_mem_we), .ds_res_from_mem(ds_res_from_mem),
    .alu_op(alu_op), .alu_src1(alu_src1), .alu_src2(alu_src2),
    .alu_result(alu_result), .alu_dout_tvalid(alu_dout_tvalid),
    .ms_allowin(ms_allowin), .es_to_ms_valid(es_to_ms_valid),
    .es_pc(es_pc), .es_result(es_result), .es_dest(es_dest),
    .es_gr_we(es_gr_we), .es_res_from_mem(es_res_from_mem),
    .data_sram_en(data_sram_en), .data_sram_we(data_sram_we),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .es_fwd_valid(es_fwd_valid), .es_fwd_dest(es_fwd_dest),
    .es_fwd_data(es_fwd_data), .es_fwd_is_load(es_fwd_is_load)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge; inputs are then driven 2 time units after it.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input logic [31:0] pc, input logic [OPW-1:0] op,
                       input logic [31:0] s1, input logic [31:0] s2,
                       input logic [31:0] rkd, input logic [DW-1:0] dst,
                       input logic gw, input logic mw, input logic rm);
    ds_to_es_valid  = 1'b1;
    ds_pc           = pc;
    ds_alu_op       = op;
    ds_src1         = s1;
    ds_src2         = s2;
    ds_rkd_value    = rkd;
    ds_dest         = dst;
    ds_gr_we        = gw;
    ds_mem_we       = mw;
    ds_res_from_mem = rm;
  endtask

  initial begin
    reset = 1'b1; ds_to_es_valid = 1'b0; ds_pc = '0; ds_alu_op = '0;
    ds_src1 = '0; ds_src2 = '0; ds_rkd_value = '0; ds_dest = '0;
    ds_gr_we = 1'b0; ds_mem_we = 1'b0; ds_res_from_mem = 1'b0;
    alu_result = '0; alu_dout_tvalid = 1'b0; ms_allowin = 1'b1;
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("rst_allowin", 32'(es_allowin), 32'd1);
    chk("rst_to_ms", 32'(es_to_ms_valid), 32'd0);
    chk("rst_alu_op", 32'(alu_op), 32'd0);
    chk("rst_pc", es_pc, 32'd0);
    chk("rst_sram_en", 32'(data_sram_en), 32'd0);
    chk("rst_fwd_valid", 32'(es_fwd_valid), 32'd0);

    // add.w 5+7
    issue(32'h1C00_0000, OP_ADD, 32'd5, 32'd7, 32'd0, 5'd3, 1'b1, 1'b0, 1'b0);
    #1 chk("add_allowin_pre", 32'(es_allowin), 32'd1);
    tick();
    ds_to_es_valid = 1'b0; alu_result = 32'd12;
    #1;
    chk("add_to_ms", 32'(es_to_ms_valid), 32'd1);
    chk("add_result", es_result, 32'd12);
    chk("add_allowin", 32'(es_allowin), 32'd1);
    chk("add_alu_op", 32'(alu_op), 32'(OP_ADD));
    chk("add_src1", alu_src1, 32'd5);
    chk("add_src2", alu_src2, 32'd7);
    chk("add_pc", es_pc, 32'h1C00_0000);
    chk("add_fwd_data", es_fwd_data, 32'd12);
    chk("add_fwd_is_load", 32'(es_fwd_is_load), 32'd0);
    tick();
    #1 chk("add_drained", 32'(es_to_ms_valid), 32'd0);

    // div.w -20/3, divider answers after 10 cycles
    issue(32'h1C00_0004, OP_DIV_W, 32'hFFFF_FFEC, 32'd3, 32'd0, 5'd5, 1'b1, 1'b0, 1'b0);
    tick();
    ds_to_es_valid = 1'b0; alu_result = 32'h0000_0BAD;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("div_allowin_busy", 32'(es_allowin), 32'd0);
      chk("div_to_ms_busy", 32'(es_to_ms_valid), 32'd0);
      chk("div_alu_op_busy", 32'(alu_op), 32'(OP_DIV_W));
      chk("div_fwd_stall", 32'(es_fwd_is_load), 32'd1);
      tick();
    end
    alu_dout_tvalid = 1'b1; alu_result = 32'hFFFF_FFFA;
    #1;
    chk("div_to_ms", 32'(es_to_ms_valid), 32'd1);
    chk("div_result", es_result, 32'hFFFF_FFFA);
    chk("div_allowin_done", 32'(es_allowin), 32'd1);
    tick();
    alu_dout_tvalid = 1'b0;
    #1 chk("div_single_xfer", 32'(es_to_ms_valid), 32'd0);

    // mod.wu 17%5 with MEM stalled on the tvalid cycle
    issue(32'h1C00_0008, OP_MOD_WU, 32'd17, 32'd5, 32'd0, 5'd6, 1'b1, 1'b0, 1'b0);
    tick();
    ds_to_es_valid = 1'b0;
    tick(); tick();
    alu_dout_tvalid = 1'b1; alu_result = 32'd2; ms_allowin = 1'b0;
    #1;
    chk("mod_result_tv", es_result, 32'd2);
    chk("mod_allowin_tv", 32'(es_allowin), 32'd0);
    tick();
    alu_dout_tvalid = 1'b1; alu_result = 32'h0000_0077;   // stray tvalid in DONE
    #1;
    chk("mod_done_op", 32'(alu_op[18:15]), 32'd0);
    chk("mod_done_hold", es_result, 32'd2);
    chk("mod_done_allowin", 32'(es_allowin), 32'd0);
    tick();
    alu_dout_tvalid = 1'b0;
    #1 chk("mod_done_hold2", es_result, 32'd2);
    tick();
    ms_allowin = 1'b1;
    #1;
    chk("mod_xfer_to_ms", 32'(es_to_ms_valid), 32'd1);
    chk("mod_xfer_result", es_result, 32'd2);
    chk("mod_xfer_allowin", 32'(es_allowin), 32'd1);
    tick();
    #1 chk("mod_drained", 32'(es_to_ms_valid), 32'd0);

    // store word with ms_allowin 0,0,1
    issue(32'h1C00_000C, OP_ADD, 32'h1000, 32'd4, 32'hDEAD_BEEF, 5'd0, 1'b0, 1'b1, 1'b0);
    tick();
    ds_to_es_valid = 1'b0; alu_result = 32'h1004; ms_allowin = 1'b0;
    #1;
    chk("st_en_wait0", 32'(data_sram_en), 32'd0);
    chk("st_we_wait0", 32'(data_sram_we), 32'd0);
    tick();
    #1 chk("st_en_wait1", 32'(data_sram_en), 32'd0);
    tick();
    ms_allowin = 1'b1;
    #1;
    chk("st_en", 32'(data_sram_en), 32'd1);
    chk("st_we", 32'(data_sram_we), 32'hF);
    chk("st_addr", data_sram_addr, 32'h1004);
    chk("st_wdata", data_sram_wdata, 32'hDEAD_BEEF);
    tick();
    #1 chk("st_en_once", 32'(data_sram_en), 32'd0);

    // load to r4, then load to r0 back-to-back
    issue(32'h1C00_0010, OP_ADD, 32'h2000, 32'd8, 32'd0, 5'd4, 1'b1, 1'b0, 1'b1);
    tick();
    alu_result = 32'h2008;
    issue(32'h1C00_0014, OP_ADD, 32'h2000, 32'd0, 32'd0, 5'd0, 1'b1, 1'b0, 1'b1);
    #1;
    chk("ld_fwd_valid", 32'(es_fwd_valid), 32'd1);
    chk("ld_fwd_is_load", 32'(es_fwd_is_load), 32'd1);
    chk("ld_fwd_dest", 32'(es_fwd_dest), 32'd4);
    chk("ld_sram_en", 32'(data_sram_en), 32'd1);
    chk("ld_sram_we", 32'(data_sram_we), 32'd0);
    tick();
    ds_to_es_valid = 1'b0;
    #1;
    chk("ld_r0_pc", es_pc, 32'h1C00_0014);
    chk("ld_r0_fwd_valid", 32'(es_fwd_valid), 32'd0);
    chk("ld_r0_fwd_is_load", 32'(es_fwd_is_load), 32'd0);
    tick();

    // back-to-back divisions: one gap cycle with div bits low
    issue(32'h1C00_0018, OP_DIV_W, 32'd100, 32'd7, 32'd0, 5'd7, 1'b1, 1'b0, 1'b0);
    tick();
    ds_to_es_valid = 1'b0;
    #1 chk("b2b_a_busy", 32'(alu_op), 32'(OP_DIV_W));
    tick();
    alu_dout_tvalid = 1'b1; alu_result = 32'd14;
    issue(32'h1C00_001C, OP_DIV_W, 32'd50, 32'd5, 32'd0, 5'd8, 1'b1, 1'b0, 1'b0);
    #1;
    chk("b2b_a_result", es_result, 32'd14);
    chk("b2b_a_allowin", 32'(es_allowin), 32'd1);
    tick();
    ds_to_es_valid = 1'b0; alu_dout_tvalid = 1'b0;
    #1;
    chk("b2b_gap_op", 32'(alu_op), 32'd0);
    chk("b2b_gap_allowin", 32'(es_allowin), 32'd0);
    chk("b2b_b_pc", es_pc, 32'h1C00_001C);
    tick();
    #1 chk("b2b_b_busy", 32'(alu_op), 32'(OP_DIV_W));
    alu_dout_tvalid = 1'b1; alu_result = 32'd10;
    #1 chk("b2b_b_to_ms", 32'(es_to_ms_valid), 32'd1);
    tick();
    alu_dout_tvalid = 1'b0;

    // reset three cycles into a division
    issue(32'h1C00_0020, OP_DIV_W, 32'd9, 32'd2, 32'd0, 5'd9, 1'b1, 1'b0, 1'b0);
    tick();
    ds_to_es_valid = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0; alu_result = '0;
    #1;
    chk("mrst_allowin", 32'(es_allowin), 32'd1);
    chk("mrst_to_ms", 32'(es_to_ms_valid), 32'd0);
    chk("mrst_alu_op", 32'(alu_op), 32'd0);
    chk("mrst_pc", es_pc, 32'd0);
    chk("mrst_dest", 32'(es_dest), 32'd0);
    alu_dout_tvalid = 1'b1; alu_result = 32'd4;
    #1 chk("mrst_stray_tv", 32'(es_to_ms_valid), 32'd0);
    tick();
    #1 chk("mrst_stray_tv2", 32'(es_to_ms_valid), 32'd0);
    alu_dout_tvalid = 1'b0;

`ifdef ES_DIVZERO_BYPASS_EN
    issue(32'h1C00_0024, OP_DIV_W, 32'd33, 32'd0, 32'd0, 5'd10, 1'b1, 1'b0, 1'b0);
    tick();
    issue(32'h1C00_0028, OP_MOD_WU, 32'd9, 32'd0, 32'd0, 5'd11, 1'b1, 1'b0, 1'b0);
    #1;
    chk("dz_div_to_ms", 32'(es_to_ms_valid), 32'd1);
    chk("dz_div_result", es_result, 32'hFFFF_FFFF);
    chk("dz_div_op", 32'(alu_op[18:15]), 32'd0);
    chk("dz_div_allowin", 32'(es_allowin), 32'd1);
    tick();
    ds_to_es_valid = 1'b0;
    #1;
    chk("dz_mod_to_ms", 32'(es_to_ms_valid), 32'd1);
    chk("dz_mod_result", es_result, 32'd9);
    tick();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
